// File: rtl/cpld_uart_responder.sv
// cpld_uart_responder: CPLD-side parallel UART model, 8N1 on txd/rxd (optional UART_LOOPBACK_EN ties RX to txd)
module cpld_uart_responder #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rdn,
    input  logic       uart_wrn,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    output logic       txd,
    input  logic       rxd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]      tx_sh_q, tx_sh_d, hold_q, hold_d, rx_sh_q, rx_sh_d, dout_q, dout_d;
    logic            tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d, wrn_q;
    logic            rx_s1_q, rx_s2_q, rx_s3_q, dr_q, dr_d, oe_q;
    logic            rx_in;

`ifdef UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_in = txd_q;
`else
    assign rx_in = rxd;
`endif

    assign data_out       = dout_q;
    assign data_oe        = oe_q;
    assign uart_dataready = dr_q;
    assign uart_tbre      = tbre_q;
    assign uart_tsre      = tsre_q;
    assign txd            = txd_q;

    // TX state, holding register, shifter and registered line output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            hold_q     <= '0;
            tbre_q     <= 1'b1;
            tsre_q     <= 1'b1;
            txd_q      <= 1'b1;
            wrn_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            hold_q     <= hold_d;
            tbre_q     <= tbre_d;
            tsre_q     <= tsre_d;
            txd_q      <= txd_d;
            wrn_q      <= uart_wrn;
        end
    end

    // Write capture on the strobe's falling edge, then IDLE/START/DATA/STOP serialization
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        hold_d     = hold_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        if (wrn_q && !uart_wrn && tbre_q) begin
            hold_d = data_in;
            tbre_d = 1'b0;
        end
        case (tx_state_q)
            S_IDLE: if (!tbre_q) begin
                tx_sh_d    = hold_q;
                tbre_d     = 1'b1;
                tsre_d     = 1'b0;
                tx_cnt_d   = FULL;
                tx_state_d = S_START;
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = FULL;
                tx_bit_d   = '0;
                tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q - ONE;
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = FULL;
                tx_sh_d    = tx_sh_q >> 1;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_state_d = (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end else tx_cnt_d = tx_cnt_q - ONE;
            default: if (tx_cnt_q == '0) begin
                tx_cnt_d = FULL;
                if (!tbre_q) begin
                    tx_sh_d    = hold_q;
                    tbre_d     = 1'b1;
                    tx_state_d = S_START;
                end else begin
                    tsre_d     = 1'b1;
                    tx_state_d = S_IDLE;
                end
            end else tx_cnt_d = tx_cnt_q - ONE;
        endcase
        txd_d = (tx_state_q == S_START) ? 1'b0 : (tx_state_q == S_DATA) ? tx_sh_q[0] : 1'b1;
    end

    // RX synchronizer, RX state, received byte and read-strobe tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            dout_q     <= '0;
            dr_q       <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            dout_q     <= dout_d;
            dr_q       <= dr_d;
            oe_q       <= ~uart_rdn;
        end
    end

    // Read-release clears dataready; a byte completing on the same cycle sets it again
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        dout_d     = dout_q;
        dr_d       = (oe_q && uart_rdn) ? 1'b0 : dr_q;
        case (rx_state_q)
            S_IDLE: if (rx_s3_q && !rx_s2_q) begin
                rx_cnt_d   = HALF;
                rx_state_d = S_START;
            end
            S_START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = FULL;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q - ONE;
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = FULL;
                rx_sh_d    = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end else rx_cnt_d = rx_cnt_q - ONE;
            default: if (rx_cnt_q == '0) begin
                if (rx_s2_q) begin
                    dout_d = rx_sh_q;
                    dr_d   = 1'b1;
                end
                rx_state_d = S_IDLE;
            end else rx_cnt_d = rx_cnt_q - ONE;
        endcase
    end
endmodule

// File: tb/tb_cpld_uart_responder.sv
// tb_cpld_uart_responder: directed self-checking bench, DIV = 8
module tb_cpld_uart_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rdn = 1'b1;
    logic       uart_wrn = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       data_oe, uart_dataready, uart_tbre, uart_tsre, txd;
    int         cmp = 0;
    int         mis = 0;

    cpld_uart_responder #(.CLK_FREQ(8), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .uart_dataready(uart_dataready), .uart_tbre(uart_tbre),
        .uart_tsre(uart_tsre), .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL reset_dataready got %b want 0", uart_dataready); end
        cmp++; if (uart_tbre !== 1'b1) begin mis++; $display("FAIL reset_tbre got %b want 1", uart_tbre); end
        cmp++; if (uart_tsre !== 1'b1) begin mis++; $display("FAIL reset_tsre got %b want 1", uart_tsre); end
        cmp++; if (txd !== 1'b1) begin mis++; $display("FAIL reset_txd got %b want 1", txd); end
        cmp++; if (data_oe !== 1'b0) begin mis++; $display("FAIL reset_oe got %b want 0", data_oe); end
        cmp++; if (data_out !== 8'h00) begin mis++; $display("FAIL reset_dout got %h want 00", data_out); end
    endtask

    task automatic test_tx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        @(negedge clk);
        uart_wrn = 1'b0;
        data_in = b;
        @(negedge clk);
        cmp++; if (uart_tbre !== 1'b0) begin mis++; $display("FAIL tx_tbre_low %h got %b want 0", b, uart_tbre); end
        uart_wrn = 1'b1;
        @(negedge clk);
        cmp++; if (uart_tbre !== 1'b1) begin mis++; $display("FAIL tx_tbre_high %h got %b want 1", b, uart_tbre); end
        cmp++; if (uart_tsre !== 1'b0) begin mis++; $display("FAIL tx_tsre_load %h got %b want 0", b, uart_tsre); end
        for (int k = 2; k <= 81; k++) begin
            @(negedge clk);
            cmp++; if (txd !== f[(k-2)/8]) begin mis++; $display("FAIL tx_bit %h cyc %0d got %b want %b", b, k, txd, f[(k-2)/8]); end
            cmp++; if (uart_tsre !== (k >= 81)) begin mis++; $display("FAIL tx_tsre %h cyc %0d got %b want %b", b, k, uart_tsre, k >= 81); end
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] g;
        g = {1'b1, 8'h34, 1'b0, 1'b1, 8'h12, 1'b0};
        @(negedge clk);
        uart_wrn = 1'b0;
        data_in = 8'h12;
        @(negedge clk);
        uart_wrn = 1'b1;
        @(negedge clk);
        cmp++; if (uart_tbre !== 1'b1) begin mis++; $display("FAIL b2b_tbre_first got %b want 1", uart_tbre); end
        uart_wrn = 1'b0;
        data_in = 8'h34;
        for (int k = 2; k <= 161; k++) begin
            @(negedge clk);
            if (k == 2) begin
                cmp++; if (uart_tbre !== 1'b0) begin mis++; $display("FAIL b2b_tbre_held got %b want 0", uart_tbre); end
                uart_wrn = 1'b1;
            end
            if (k == 3) begin uart_wrn = 1'b0; data_in = 8'h56; end
            if (k == 4) uart_wrn = 1'b1;
            cmp++; if (txd !== g[(k-2)/8]) begin mis++; $display("FAIL b2b_bit cyc %0d got %b want %b", k, txd, g[(k-2)/8]); end
            cmp++; if (uart_tsre !== (k >= 161)) begin mis++; $display("FAIL b2b_tsre cyc %0d got %b want %b", k, uart_tsre, k >= 161); end
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cmp++; if (txd !== 1'b1) begin mis++; $display("FAIL b2b_no_third cyc %0d got %b want 1", k, txd); end
        end
        cmp++; if (uart_tbre !== 1'b1) begin mis++; $display("FAIL b2b_tbre_end got %b want 1", uart_tbre); end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (8) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rx_read;
        drive_frame(8'h3C, 1'b1);
        cmp++; if (uart_dataready !== 1'b1) begin mis++; $display("FAIL rx_dataready got %b want 1", uart_dataready); end
        cmp++; if (data_out !== 8'h3C) begin mis++; $display("FAIL rx_dout got %h want 3c", data_out); end
        cmp++; if (data_oe !== 1'b0) begin mis++; $display("FAIL rd_oe_before got %b want 0", data_oe); end
        uart_rdn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp++; if (data_oe !== 1'b1) begin mis++; $display("FAIL rd_oe_high cyc %0d got %b want 1", i, data_oe); end
            cmp++; if (uart_dataready !== 1'b1) begin mis++; $display("FAIL rd_dr_hold cyc %0d got %b want 1", i, uart_dataready); end
        end
        uart_rdn = 1'b1;
        @(negedge clk);
        cmp++; if (data_oe !== 1'b0) begin mis++; $display("FAIL rd_oe_low got %b want 0", data_oe); end
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL rd_dr_clear got %b want 0", uart_dataready); end
        cmp++; if (data_out !== 8'h3C) begin mis++; $display("FAIL rd_dout_keep got %h want 3c", data_out); end
    endtask

    task automatic test_framing;
        drive_frame(8'h77, 1'b0);
        repeat (5) @(negedge clk);
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL frame_err_dr got %b want 0", uart_dataready); end
        cmp++; if (data_out !== 8'h3C) begin mis++; $display("FAIL frame_err_dout got %h want 3c", data_out); end
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL glitch_dr got %b want 0", uart_dataready); end
        cmp++; if (data_out !== 8'h3C) begin mis++; $display("FAIL glitch_dout got %h want 3c", data_out); end
    endtask

    task automatic test_overwrite;
        drive_frame(8'h5A, 1'b1);
        cmp++; if (data_out !== 8'h5A) begin mis++; $display("FAIL ovr_first got %h want 5a", data_out); end
        drive_frame(8'h96, 1'b1);
        cmp++; if (uart_dataready !== 1'b1) begin mis++; $display("FAIL ovr_dr got %b want 1", uart_dataready); end
        cmp++; if (data_out !== 8'h96) begin mis++; $display("FAIL ovr_dout got %h want 96", data_out); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        uart_wrn = 1'b0;
        data_in = 8'hFF;
        rxd = 1'b0;
        @(negedge clk);
        uart_wrn = 1'b1;
        repeat (30) @(negedge clk);
        cmp++; if (uart_tsre !== 1'b0) begin mis++; $display("FAIL mid_busy_tsre got %b want 0", uart_tsre); end
        rst = 1'b1;
        rxd = 1'b1;
        #1;
        cmp++; if (txd !== 1'b1) begin mis++; $display("FAIL mid_txd got %b want 1", txd); end
        cmp++; if (uart_tsre !== 1'b1) begin mis++; $display("FAIL mid_tsre got %b want 1", uart_tsre); end
        cmp++; if (uart_tbre !== 1'b1) begin mis++; $display("FAIL mid_tbre got %b want 1", uart_tbre); end
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL mid_dr got %b want 0", uart_dataready); end
        cmp++; if (data_out !== 8'h00) begin mis++; $display("FAIL mid_dout got %h want 00", data_out); end
        cmp++; if (data_oe !== 1'b0) begin mis++; $display("FAIL mid_oe got %b want 0", data_oe); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_tx(8'h81);
        repeat (20) @(negedge clk);
        cmp++; if (uart_dataready !== 1'b0) begin mis++; $display("FAIL mid_no_rx got %b want 0", uart_dataready); end
    endtask

`ifdef UART_LOOPBACK_EN
    task automatic test_loopback;
        rxd = 1'b0;
        test_tx(8'hC3);
        repeat (10) @(negedge clk);
        cmp++; if (uart_dataready !== 1'b1) begin mis++; $display("FAIL loop_dr got %b want 1", uart_dataready); end
        cmp++; if (data_out !== 8'hC3) begin mis++; $display("FAIL loop_dout got %h want c3", data_out); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_LOOPBACK_EN
        test_loopback();
`else
        test_tx(8'hA5);
        test_back_to_back();
        test_rx_read();
        test_framing();
        test_overwrite();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule

// File: doc/cpld_uart_responder.md
# cpld_uart_responder

Synthesizable model of the CPLD serial controller side of the board's parallel UART interface. It answers the `uart_rdn`/`uart_wrn` strobes issued by the serial controller, drives `uart_dataready`/`uart_tbre`/`uart_tsre`, and serializes and deserializes bytes on `txd`/`rxd` as 8N1. It lets the serial controller be exercised end-to-end on FPGA, or in simulation without the physical CPLD. Tri-stating of the shared data byte is done by the instantiating level using `data_oe`.

## Interface

- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `DIV = CLK_FREQ / BAUD`, integer division, truncated. `DIV` must be ≥ 4.

- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  asynchronous reset, active-high.
- `uart_rdn`  in  1  read strobe, low-active, synchronous to `clk`.
- `uart_wrn`  in  1  write strobe, low-active, synchronous to `clk`.
- `data_in`  in  8  byte driven by the initiator during writes.
- `data_out`  out  8  received byte.
- `data_oe`  out  1  high while the block must drive the shared byte lane.
- `uart_dataready`  out  1  an unread received byte is held.
- `uart_tbre`  out  1  transmit holding register empty.
- `uart_tsre`  out  1  transmit shifter empty (line idle).
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous.

## Operation

- Reset values:
  - `uart_dataready` = 0, `uart_tbre` = 1, `uart_tsre` = 1.
  - `txd` = 1, `data_oe` = 0, `data_out` = 0x00.
  - Both FSMs return to IDLE.
  - Reset asserted mid-frame aborts the frame immediately: `txd` goes to 1 and any partial RX byte is discarded.
- Write path:
  - On the first cycle `uart_wrn` is sampled low (falling edge), `data_in` is latched into the holding register and `uart_tbre` clears.
  - A write while `uart_tbre` = 0 is ignored. The held byte is unchanged.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the holding register is full, move its byte to the shifter, set `uart_tbre` = 1 and `uart_tsre` = 0, then go to START.
  - START, DATA and STOP each last `DIV` cycles per bit. START drives 0. DATA sends 8 bits, LSB first. STOP drives 1.
  - At the end of STOP:
    - If the holding register is full, reload it and go to START without an idle bit. `uart_tsre` stays 0.
    - Otherwise set `uart_tsre` = 1 and go to IDLE.
- RX path:
  - `rxd` passes through a 2-FF synchronizer.
  - RX FSM states: IDLE → START → DATA → STOP.
  - IDLE waits for a 1→0 transition of the synchronized input.
  - START re-checks the line at `DIV/2` cycles. If it is 1, the start is false and the FSM returns to IDLE.
  - DATA samples 8 bits, each `DIV` cycles after the previous sample.
  - STOP samples once more after `DIV` cycles:
    - 1: the byte goes to `data_out` and `uart_dataready` is set.
    - 0: framing error. The byte is discarded and flags are unchanged.
  - A new valid byte arriving while `uart_dataready` = 1 overwrites `data_out`. `uart_dataready` stays 1.
- Read path:
  - `data_oe` = ~`uart_rdn`, registered, so it follows the strobe with one cycle of latency.
  - `uart_dataready` clears on the first cycle `uart_rdn` is sampled high after being low (rising edge).
  - If a new byte completes on that same cycle, the new byte wins: `uart_dataready` stays 1 and `data_out` updates.
- Simultaneous `uart_rdn` and `uart_wrn` low: both are honoured independently.

## Timing

- Write latency:
  - `uart_tbre` falls 1 cycle after the `uart_wrn` falling edge is sampled, and rises again 1 cycle later if TX was idle.
  - `txd` start bit begins 2 cycles after the edge.
- Frame length: exactly `10*DIV` cycles. Back-to-back frames have zero gap.
- RX completion: `uart_dataready` rises 1 cycle after the stop-bit sample, which is about `9.5*DIV` cycles after the start edge plus 2 synchronizer cycles.
- Baud counter: `$clog2(DIV)` bits. It reloads at 0 and restarts on every state entry.

## Configuration

- `UART_LOOPBACK_EN` defined:
  - The RX synchronizer input is tied to internal `txd`, and external `rxd` is ignored.
  - `txd` still drives the pin.
- `UART_LOOPBACK_EN` undefined: RX input is `rxd`.

## Test plan

All scenarios use `CLK_FREQ=8`, `BAUD=1` (`DIV=8`).

- **Write single byte:** write 0xA5 → `uart_tbre` low 1 cycle then high. `txd` shows 0,1,0,1,0,0,1,0,1,1, 8 cycles per bit. `uart_tsre` rises 80 cycles after the load.
- **Back-to-back writes:** write 0x12, then write 0x34 while `uart_tbre` = 1. A third write of 0x56 is issued while `uart_tbre` = 0 → 0x12 then 0x34 go out contiguously in 160 cycles, 0x56 is never sent, and `uart_tsre` = 0 throughout.
- **Receive and read:** drive an 8N1 frame of 0x3C on `rxd` → `uart_dataready` = 1 and `data_out` = 0x3C. Pulse `uart_rdn` low for 3 cycles → `data_oe` high for 3 cycles, lagging the strobe by 1 cycle. `uart_dataready` = 0 after the rising edge.
- **Framing error and false start:** a frame 0x77 with stop bit 0 → `uart_dataready` stays 0. A 2-cycle low glitch on `rxd` → no reception.
- **Reset mid-operation:** assert `rst` during the DATA bits of TX 0xFF and RX 0x00 → `txd` = 1 and all flags at reset values immediately. A following write of 0x81 transmits correctly.
- **Loopback (`UART_LOOPBACK_EN` defined):** write 0xC3 while `rxd` is held at 0 → `uart_dataready` = 1 and `data_out` = 0xC3.
